// File: rtl/booth4_pkg.sv
// Shared definitions for the radix-4 Booth mantissa multiplier datapaths.
package booth4_pkg;
    localparam int MANT_W     = 24;
    localparam int NUM_DIGITS = MANT_W / 2 + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } digit_sel_t;
endpackage

// File: rtl/booth4_digit_enc.sv
// Radix-4 Booth recoder: one 3-bit multiplier window to a digit select.
module booth4_digit_enc
    import booth4_pkg::*;
(
    input  logic [2:0] i_win,
    output digit_sel_t o_sel
);
    always_comb begin
        // 111 is a zero digit, so it must not request a negation
        o_sel.neg = i_win[2] & ~(i_win[1] & i_win[0]);
        o_sel.one = i_win[1] ^ i_win[0];
        o_sel.two = (i_win == 3'b011) | (i_win == 3'b100);
    end
endmodule

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one partial product accumulated per cycle,
// with valid/ready handshakes on operand and product sides.
module booth4_seq_mult #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_W-1:0]     mant_a,
    input  logic [MANT_W-1:0]     mant_b,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   product,
    output logic                  busy
);
    import booth4_pkg::*;

    localparam int ND    = MANT_W / 2 + 1;
    localparam int ACC_W = 2 * MANT_W + 2;
    localparam int BX_W  = MANT_W + 3;
    localparam int CNT_W = $clog2(ND);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [MANT_W-1:0]   r_a;
    logic [BX_W-1:0]     r_bx;
    logic [ACC_W-1:0]    r_acc;
    logic [2*MANT_W-1:0] r_product;

    logic [2:0]          w_win;
    digit_sel_t          w_sel;
    logic [MANT_W+1:0]   w_mag;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;

    assign w_win = 3'(r_bx >> {r_cnt, 1'b0});

    booth4_digit_enc u_enc (
        .i_win (w_win),
        .o_sel (w_sel)
    );

    // Negative digits invert the shifted magnitude and add 1 as the adder carry-in
    assign w_mag    = w_sel.two ? {1'b0, r_a, 1'b0} :
                      w_sel.one ? {2'b00, r_a}      : '0;
    assign w_addend = {ACC_W{w_sel.neg}} ^
                      ({{(ACC_W-MANT_W-2){1'b0}}, w_mag} << {r_cnt, 1'b0});
    assign w_sum    = r_acc + w_addend + {{(ACC_W-1){1'b0}}, w_sel.neg};
    assign w_last   = (r_cnt == CNT_W'(ND - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_bx      <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (abort) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= mant_a;
                        r_bx    <= {2'b00, mant_b, 1'b0};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_product <= w_sum[2*MANT_W-1:0];
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) | (r_state == DONE);
    assign product   = r_product;

    // Unsigned operands never reach the two guard bits of the accumulator
    a_acc_guard: assert property (@(posedge clk) disable iff (!n_rst)
        (r_state == RUN && w_last && !abort) |-> (w_sum[ACC_W-1:2*MANT_W] == 2'b00));
endmodule
